dmem_wait_responder: RTL and testbench
======================================

// Module: dmem_wait_responder
// PURPOSE
//  Memory-side responder for the pipelined core's load/store port. Takes one access per request from the MEM stage.
//  Holds the pipeline with busy for a fixed number of wait states, then performs the byte/half/word access.
//  Returns load data with a one-cycle resp_valid pulse.
//  Replaces the zero-wait data memory so the stall path (busy) is exercised by real memory timing.
// PARAMETERS
//  DEPTH    1024  words of storage; power of two
//  LATENCY  2     wait-state cycles per access; legal range 1..15
// PORTS
//  clk         in   1   single clock, rising edge
//  reset       in   1   asynchronous, active-high
//  req_rd      in   3   load op: 000 none, 001 LB, 010 LH, 011 LW, 100 LBU, 101 LHU
//  req_wr      in   2   store op: 00 none, 01 SB, 10 SH, 11 SW
//  req_addr    in   32  byte address (ALU result)
//  req_wdata   in   32  store data, right-aligned
//  busy        out  1   stall request to PC/pipeline registers
//  resp_valid  out  1   one-cycle pulse: access complete, rdata valid
//  rdata       out  32  load result, extended per req_rd; 0 for stores
//  misalign    out  1   pulses with resp_valid when the access was misaligned (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async) behaviour
//   - state=IDLE; busy=0, resp_valid=0, rdata=0, misalign=0.
//   - Storage contents are not cleared.
//   - Reset mid-access aborts it; a store in flight is not committed.
//  Request and state machine: IDLE -> WAIT -> RESP -> IDLE
//   - A request is active when req_rd!=0 or req_wr!=0.
//   - IDLE: busy = request active (combinational). On an active request, latch op/addr/wdata, load cnt=LATENCY-1, go to WAIT.
//   - WAIT: busy=1. cnt!=0 -> cnt-1. cnt==0 -> perform access at this edge, register rdata, go to RESP.
//   - RESP: busy=0, resp_valid=1, rdata held. The request inputs are ignored here: the pipeline still presents the same op this cycle. Go to IDLE.
//  Timing
//   - Request first seen in cycle T: busy is high T..T+LATENCY, resp_valid is high in T+LATENCY+1.
//   - Back-to-back accesses are therefore separated by at least one IDLE cycle.
//  Storage and data rules
//   - Word index = addr[log2(DEPTH)+1:2], i.e. the address wraps modulo DEPTH*4.
//   - Stores use byte enables from addr[1:0] and op width:
//     - SB writes the lane addr[1:0] with wdata[7:0].
//     - SH writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
//     - SW writes all four lanes.
//   - Loads extract the same lanes. LB/LH sign-extend; LBU/LHU zero-extend.
//   - req_rd and req_wr both nonzero: the store wins, the load is ignored, rdata=0.
//   - Unused encodings (req_rd 110/111) behave as LW.
// CONFIGURATION
//  DMEM_MISALIGN_TRAP_EN defined
//   - Misaligned accesses (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0) are still handshaked normally.
//   - No storage write occurs, rdata=0, and misalign=1 in the RESP cycle.
//  DMEM_MISALIGN_TRAP_EN undefined
//   - The offending low address bits are forced to 0 and the access proceeds.
//   - misalign is tied to 0.
// STRUCTURE
//  Shared package dmem_pkg
//   - localparams for the req_rd/req_wr encodings.
//   - FSM state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2).
//   - LATENCY counter width (4).
//  One sub-module: dmem_lane_align (combinational)
//   - Inputs: op, addr[1:0], wdata, stored word.
//   - Outputs: byte-enable[3:0], merged write word, extended load value, misaligned flag.
//  Top level holds the FSM, counter, request latches and storage array.
// TESTING
//  1 Reset with all inputs idle -> busy=0, resp_valid=0, rdata=0 in the first cycle after release.
//  2 SW 0xDEADBEEF to 0x10, then LW 0x10, LATENCY=2 -> busy high 3 cycles per access; LW resp_valid pulse returns rdata=0xDEADBEEF.
//  3 After test 2, check byte/half extraction and extension:
//    - LB 0x13 -> 0xFFFFFFDE.
//    - LBU 0x13 -> 0x000000DE.
//    - LH 0x10 -> 0xFFFFBEEF.
//    - LHU 0x12 -> 0x0000DEAD.
//  4 SB 0xAA to 0x11 over 0xDEADBEEF, then LW 0x10 -> 0xDEADAAEF; the other lanes are unchanged.
//  5 LW 0x12 misaligned:
//    - with DMEM_MISALIGN_TRAP_EN -> misalign=1, rdata=0.
//    - without -> rdata=word@0x10, misalign=0.
//  6 Assert reset mid-WAIT of SW 0x55 to 0x20, then LW 0x20 -> prior contents returned; busy drops immediately on reset.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared encodings for the wait-state data memory responder: load/store op codes,
// FSM states and the wait-state counter width.
package dmem_pkg;

  localparam logic [2:0] RD_NONE = 3'b000;
  localparam logic [2:0] RD_LB   = 3'b001;
  localparam logic [2:0] RD_LH   = 3'b010;
  localparam logic [2:0] RD_LW   = 3'b011;
  localparam logic [2:0] RD_LBU  = 3'b100;
  localparam logic [2:0] RD_LHU  = 3'b101;

  localparam logic [1:0] WR_NONE = 2'b00;
  localparam logic [1:0] WR_SB   = 2'b01;
  localparam logic [1:0] WR_SH   = 2'b10;
  localparam logic [1:0] WR_SW   = 2'b11;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_wait_responder_if.sv
// Load/store port between the pipeline MEM stage (master) and the data memory (slave).
interface dmem_wait_responder_if;

  logic [2:0]  req_rd;
  logic [1:0]  req_wr;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        busy;
  logic        resp_valid;
  logic [31:0] rdata;
  logic        misalign;

  modport master (
    output req_rd, req_wr, req_addr, req_wdata,
    input  busy, resp_valid, rdata, misalign
  );

  modport slave (
    input  req_rd, req_wr, req_addr, req_wdata,
    output busy, resp_valid, rdata, misalign
  );

endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for loads/stores: byte enables, write merge, load extension.
// DMEM_MISALIGN_TRAP_EN: misaligned accesses are suppressed and flagged instead of aligned down.
import dmem_pkg::*;

module dmem_lane_align (
  input  logic [2:0]  rd,
  input  logic [1:0]  wr,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] load_val,
  output logic        misaligned
);

  logic        is_store;
  logic        is_byte;
  logic        is_half;
  logic        is_word;
  logic        sign_ext;
  logic [1:0]  lane;
  logic [7:0]  byte_val;
  logic [15:0] half_val;
  logic [31:0] wrep;

  // A store takes precedence over a simultaneous load; unused load codes act as LW.
  always_comb begin
    is_store = (wr != WR_NONE);
    is_byte  = 1'b0;
    is_half  = 1'b0;
    sign_ext = 1'b0;
    if (is_store) begin
      is_byte = (wr == WR_SB);
      is_half = (wr == WR_SH);
    end else begin
      case (rd)
        RD_LB:   begin is_byte = 1'b1; sign_ext = 1'b1; end
        RD_LBU:  is_byte = 1'b1;
        RD_LH:   begin is_half = 1'b1; sign_ext = 1'b1; end
        RD_LHU:  is_half = 1'b1;
        default: ;
      endcase
    end
    is_word = !is_byte && !is_half;
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  assign lane       = addr_lo;
  assign misaligned = (is_half && addr_lo[0]) || (is_word && (addr_lo != 2'b00));
`else
  assign lane       = is_word ? 2'b00 : (is_half ? {addr_lo[1], 1'b0} : addr_lo);
  assign misaligned = 1'b0;
`endif

  always_comb begin
    be       = 4'b0000;
    wword    = rword;
    load_val = 32'h0;
    byte_val = rword[8*lane +: 8];
    half_val = lane[1] ? rword[31:16] : rword[15:0];
    wrep     = is_byte ? {4{wdata[7:0]}} : (is_half ? {2{wdata[15:0]}} : wdata);
    if (!misaligned) begin
      if (is_store) begin
        be = is_byte ? (4'b0001 << lane) : (is_half ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111);
        for (int i = 0; i < 4; i++) begin
          if (be[i]) wword[8*i +: 8] = wrep[8*i +: 8];
        end
      end else if (is_byte) begin
        load_val = {{24{sign_ext & byte_val[7]}}, byte_val};
      end else if (is_half) begin
        load_val = {{16{sign_ext & half_val[15]}}, half_val};
      end else begin
        load_val = rword;
      end
    end
  end

endmodule

// File: rtl/dmem_wait_responder.sv
// Data memory responder that stalls the pipeline for LATENCY wait states per access.
// Misaligned handling is selected in dmem_lane_align by DMEM_MISALIGN_TRAP_EN.
import dmem_pkg::*;

module dmem_wait_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input logic                  clk,
  input logic                  reset,
  dmem_wait_responder_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  state_t          state;
  state_t          state_next;
  logic [CNT_W-1:0] cnt;
  logic [2:0]      rd_q;
  logic [1:0]      wr_q;
  logic [AW+1:0]   addr_q;
  logic [31:0]     wdata_q;
  logic [31:0]     rdata_q;
  logic            mis_q;
  logic [31:0]     mem [DEPTH];

  logic            req_active;
  logic            access_now;
  logic [AW-1:0]   widx;
  logic [31:0]     rword;
  logic [31:0]     wword;
  logic [31:0]     load_val;
  logic [3:0]      be;
  logic            misaligned;

  assign req_active = (bus.req_rd != RD_NONE) || (bus.req_wr != WR_NONE);
  assign access_now = (state == WAIT) && (cnt == '0);
  assign widx       = addr_q[AW+1:2];
  assign rword      = mem[widx];

  dmem_lane_align u_lane_align (
    .rd         (rd_q),
    .wr         (wr_q),
    .addr_lo    (addr_q[1:0]),
    .wdata      (wdata_q),
    .rword      (rword),
    .be         (be),
    .wword      (wword),
    .load_val   (load_val),
    .misaligned (misaligned)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_active) state_next = WAIT;
      WAIT:    if (cnt == '0) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      rd_q    <= RD_NONE;
      wr_q    <= WR_NONE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
    end else begin
      if (state == IDLE && req_active) begin
        cnt     <= CNT_W'(LATENCY - 1);
        rd_q    <= bus.req_rd;
        wr_q    <= bus.req_wr;
        addr_q  <= bus.req_addr[AW+1:0];
        wdata_q <= bus.req_wdata;
      end else if (state == WAIT) begin
        if (cnt != '0) begin
          cnt <= cnt - 1'b1;
        end else begin
          rdata_q <= load_val;
          mis_q   <= misaligned;
        end
      end
    end
  end

  // Storage is never cleared; gating on reset keeps an aborted store from landing.
  always_ff @(posedge clk) begin
    if (access_now && !reset && (be != 4'b0000)) mem[widx] <= wword;
  end

  always_comb begin
    bus.busy       = 1'b0;
    bus.resp_valid = 1'b0;
    bus.rdata      = rdata_q;
    bus.misalign   = 1'b0;
    if (!reset) begin
      case (state)
        IDLE:    bus.busy = req_active;
        WAIT:    bus.busy = 1'b1;
        RESP: begin
          bus.resp_valid = 1'b1;
          bus.misalign   = mis_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_wait_responder.sv
// Directed bench for dmem_wait_responder: handshake timing, lane extraction,
// misaligned handling (either build of DMEM_MISALIGN_TRAP_EN) and reset abort.
import dmem_pkg::*;

module tb_dmem_wait_responder;

  localparam int DEPTH   = 1024;
  localparam int LATENCY = 2;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] mem10;

  dmem_wait_responder_if bus ();

  dmem_wait_responder #(
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic clear_inputs();
    bus.req_rd    = RD_NONE;
    bus.req_wr    = WR_NONE;
    bus.req_addr  = 32'h0;
    bus.req_wdata = 32'h0;
  endtask

  // Present one request and hold it until the response pulse (bounded wait).
  task automatic apply_stimulus(input logic [2:0] rd, input logic [1:0] wr,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output logic [31:0] rdata_o, output logic mis_o,
                                output int busy_cycles, output bit got_resp);
    @(negedge clk);
    bus.req_rd    = rd;
    bus.req_wr    = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    got_resp    = 1'b0;
    busy_cycles = 0;
    rdata_o     = 32'h0;
    mis_o       = 1'b0;
    for (int i = 0; i < 40 && !got_resp; i++) begin
      #1;
      if (bus.busy) busy_cycles++;
      if (bus.resp_valid) begin
        got_resp = 1'b1;
        rdata_o  = bus.rdata;
        mis_o    = bus.misalign;
      end else begin
        @(negedge clk);
      end
    end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic access_check(input string tag, input logic [2:0] rd, input logic [1:0] wr,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_rdata, input logic exp_mis);
    logic [31:0] rdata_o;
    logic        mis_o;
    int          busy_cycles;
    bit          got_resp;
    apply_stimulus(rd, wr, addr, wdata, rdata_o, mis_o, busy_cycles, got_resp);
    check_output({tag, "_resp"}, 32'(got_resp), 32'd1);
    check_output({tag, "_busy"}, 32'(busy_cycles), 32'(LATENCY + 1));
    check_output({tag, "_rdata"}, rdata_o, exp_rdata);
    check_output({tag, "_mis"}, 32'(mis_o), 32'(exp_mis));
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check_output("rst_busy", 32'(bus.busy), 32'd0);
    check_output("rst_resp", 32'(bus.resp_valid), 32'd0);
    check_output("rst_rdata", bus.rdata, 32'h0);
    check_output("rst_mis", 32'(bus.misalign), 32'd0);

    access_check("sw10", RD_NONE, WR_SW, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    access_check("lw10", RD_LW, WR_NONE, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

    access_check("lb13",  RD_LB,  WR_NONE, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0);
    access_check("lbu13", RD_LBU, WR_NONE, 32'h13, 32'h0, 32'h000000DE, 1'b0);
    access_check("lh10",  RD_LH,  WR_NONE, 32'h10, 32'h0, 32'hFFFFBEEF, 1'b0);
    access_check("lhu12", RD_LHU, WR_NONE, 32'h12, 32'h0, 32'h0000DEAD, 1'b0);

    access_check("sb11", RD_NONE, WR_SB, 32'h11, 32'h000000AA, 32'h0, 1'b0);
    access_check("lw10b", RD_LW, WR_NONE, 32'h10, 32'h0, 32'hDEADAAEF, 1'b0);

`ifdef DMEM_MISALIGN_TRAP_EN
    access_check("lw12_mis", RD_LW, WR_NONE, 32'h12, 32'h0, 32'h0, 1'b1);
    access_check("lh11_mis", RD_LH, WR_NONE, 32'h11, 32'h0, 32'h0, 1'b1);
    access_check("sh13_mis", RD_NONE, WR_SH, 32'h13, 32'h00001234, 32'h0, 1'b1);
    mem10 = 32'hDEADAAEF;
`else
    access_check("lw12_mis", RD_LW, WR_NONE, 32'h12, 32'h0, 32'hDEADAAEF, 1'b0);
    access_check("lh11_mis", RD_LH, WR_NONE, 32'h11, 32'h0, 32'hFFFFAAEF, 1'b0);
    access_check("sh13_mis", RD_NONE, WR_SH, 32'h13, 32'h00001234, 32'h0, 1'b0);
    mem10 = 32'h1234AAEF;
`endif
    access_check("lw10c", RD_LW, WR_NONE, 32'h10, 32'h0, mem10, 1'b0);

    access_check("both", RD_LW, WR_SB, 32'h10, 32'h00000077, 32'h0, 1'b0);
    mem10 = {mem10[31:8], 8'h77};
    access_check("lw10d", RD_LW, WR_NONE, 32'h10, 32'h0, mem10, 1'b0);
    access_check("lw_wrap", RD_LW, WR_NONE, 32'h10 + 32'(DEPTH * 4), 32'h0, mem10, 1'b0);
    access_check("rd110", 3'b110, WR_NONE, 32'h10, 32'h0, mem10, 1'b0);

    access_check("sw20", RD_NONE, WR_SW, 32'h20, 32'h12345678, 32'h0, 1'b0);
    access_check("lw20", RD_LW, WR_NONE, 32'h20, 32'h0, 32'h12345678, 1'b0);

    // Abort a store in its wait states; it must never reach storage.
    @(negedge clk);
    bus.req_wr    = WR_SW;
    bus.req_addr  = 32'h20;
    bus.req_wdata = 32'h00000055;
    @(negedge clk);
    #1;
    check_output("abort_pre_busy", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    #1;
    check_output("abort_busy", 32'(bus.busy), 32'd0);
    check_output("abort_resp", 32'(bus.resp_valid), 32'd0);
    clear_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check_output("abort_idle_busy", 32'(bus.busy), 32'd0);
    access_check("lw20_after", RD_LW, WR_NONE, 32'h20, 32'h0, 32'h12345678, 1'b0);
    access_check("lbu21", RD_LBU, WR_NONE, 32'h21, 32'h0, 32'h00000056, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
